// File: rtl/execute_mul_pkg.sv
`default_nettype none
// ============================================================================
// Package  : execute_mul_pkg
// Brief    : Shared payload type, flag indices and seed default for the MUL stage.
// Revision : 1.0
// ============================================================================

// Command codes normally come from core.h; these fallbacks apply only when it is absent.
`ifndef EXE_MUL_MUL
`define EXE_MUL_MUL   5'h00
`endif
`ifndef EXE_MUL_MULH
`define EXE_MUL_MULH  5'h01
`endif
`ifndef EXE_MUL_UMULH
`define EXE_MUL_UMULH 5'h02
`endif
`ifndef EXE_MUL_RAND
`define EXE_MUL_RAND  5'h03
`endif

package execute_mul_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  flags;
        logic [4:0]  dest;
        logic        wb;
    } mul_payload_t;

    localparam int FLAG_SF = 4;
    localparam int FLAG_OF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 0;

    localparam logic [31:0] SEED_INIT_DEFAULT = 32'h0000_0001;

endpackage

`default_nettype wire

// File: rtl/execute_mul_stage_if.sv
`default_nettype none
// ============================================================================
// Interface : execute_mul_stage_if
// Brief     : Dispatch, combinational-unit and writeback signals of the MUL stage.
// Revision  : 1.0
// ============================================================================

interface execute_mul_stage_if;

    logic        iFREE_REFRESH;
    logic        iPREV_VALID;
    logic        oPREV_BUSY;
    logic [4:0]  iCMD;
    logic [31:0] iDATA_0;
    logic [31:0] iDATA_1;
    logic [4:0]  iDESTINATION;
    logic [4:0]  oMUL_CMD;
    logic [31:0] oMUL_DATA_0;
    logic [31:0] oMUL_DATA_1;
    logic [31:0] iMUL_DATA;
    logic [4:0]  iMUL_FLAGS;
    logic        oNEXT_VALID;
    logic        iNEXT_BUSY;
    logic [31:0] oNEXT_DATA;
    logic [4:0]  oNEXT_FLAGS;
    logic        oNEXT_FLAGS_WRITEBACK;
    logic [4:0]  oNEXT_DESTINATION;

    modport slave (
        input  iFREE_REFRESH, iPREV_VALID, iCMD, iDATA_0, iDATA_1, iDESTINATION,
               iMUL_DATA, iMUL_FLAGS, iNEXT_BUSY,
        output oPREV_BUSY, oMUL_CMD, oMUL_DATA_0, oMUL_DATA_1, oNEXT_VALID,
               oNEXT_DATA, oNEXT_FLAGS, oNEXT_FLAGS_WRITEBACK, oNEXT_DESTINATION
    );

    modport master (
        output iFREE_REFRESH, iPREV_VALID, iCMD, iDATA_0, iDATA_1, iDESTINATION,
               iMUL_DATA, iMUL_FLAGS, iNEXT_BUSY,
        input  oPREV_BUSY, oMUL_CMD, oMUL_DATA_0, oMUL_DATA_1, oNEXT_VALID,
               oNEXT_DATA, oNEXT_FLAGS, oNEXT_FLAGS_WRITEBACK, oNEXT_DESTINATION
    );

endinterface

`default_nettype wire

// File: rtl/execute_mul_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : execute_mul_result_fifo
// Brief    : Count-tracked circular result FIFO with flush; head reads as zero when empty.
// Revision : 1.0
// ============================================================================

module execute_mul_result_fifo
    import execute_mul_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    input  wire logic                       flush,
    input  wire logic                       write,
    input  wire mul_payload_t               wdata,
    input  wire logic                       pop,
    output mul_payload_t                    rdata,
    output logic [$clog2(DEPTH + 1) - 1:0]  count
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    mul_payload_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
        return (ptr == LAST) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write) wr_ptr <= advance(wr_ptr);
            if (pop)   rd_ptr <= advance(rd_ptr);
            if (write && !pop)      count <= count + CW'(1);
            else if (!write && pop) count <= count - CW'(1);
        end
    end

    // Write-while-full lands in the slot being popped, which is read combinationally first.
    always_ff @(posedge clk) begin
        if (write) mem[wr_ptr] <= wdata;
    end

    assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

`default_nettype wire

// File: rtl/execute_mul_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_mul_stage
// Brief    : Registered wrapper around the combinational MUL/RAND unit; owns the RAND seed.
// Revision : 1.0
// ============================================================================

module execute_mul_stage
    import execute_mul_pkg::*;
#(
    parameter int          LATENCY    = 2,
    parameter int          FIFO_DEPTH = 3,
    parameter logic [31:0] SEED_INIT  = SEED_INIT_DEFAULT
) (
    input  wire logic          iCLOCK,
    input  wire logic          inRESET,
    execute_mul_stage_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                        is_rand;
    logic                        busy;
    logic                        accept;
    logic                        pop;
    logic                        fifo_write;
    logic                        fifo_valid;
    logic [CW-1:0]               credit;
    logic [CW-1:0]               fifo_count;
    logic [31:0]                 seed;
    logic [LATENCY-1:0]          stg_valid;
    logic [LATENCY-1:0]          valid_shift;
    mul_payload_t [LATENCY-1:0]  stg_data;
    mul_payload_t [LATENCY-1:0]  data_shift;
    mul_payload_t                in_payload;
    mul_payload_t                head;

    assign is_rand = (bus.iCMD == `EXE_MUL_RAND);

    assign bus.oMUL_CMD    = bus.iCMD;
    assign bus.oMUL_DATA_0 = bus.iDATA_0;
    assign bus.oMUL_DATA_1 = is_rand ? seed : bus.iDATA_1;

    // Credits cover in-flight plus queued results, so the FIFO can never overflow.
    assign busy           = (credit >= CW'(FIFO_DEPTH));
    assign bus.oPREV_BUSY = busy;
    assign accept         = bus.iPREV_VALID & ~busy & ~bus.iFREE_REFRESH;
    assign fifo_valid     = (fifo_count != '0);
    assign pop            = fifo_valid & ~bus.iNEXT_BUSY & ~bus.iFREE_REFRESH;
    assign fifo_write     = stg_valid[LATENCY-1] & ~bus.iFREE_REFRESH;

    assign in_payload = '{data:  bus.iMUL_DATA,
                          flags: bus.iMUL_FLAGS,
                          dest:  bus.iDESTINATION,
                          wb:    ~is_rand};

    generate
        if (LATENCY == 1) begin : g_lat_single
            assign valid_shift = accept;
            assign data_shift  = in_payload;
        end else begin : g_lat_multi
            assign valid_shift = {stg_valid[LATENCY-2:0], accept};
            assign data_shift  = {stg_data[LATENCY-2:0], in_payload};
        end
    endgenerate

    always_ff @(posedge iCLOCK) begin
        if (!inRESET || bus.iFREE_REFRESH) stg_valid <= '0;
        else                               stg_valid <= valid_shift;
    end

    always_ff @(posedge iCLOCK) begin
        stg_data <= data_shift;
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET || bus.iFREE_REFRESH) credit <= '0;
        else if (accept && !pop)           credit <= credit + CW'(1);
        else if (!accept && pop)           credit <= credit - CW'(1);
    end

    // Flush never rewinds the seed: a RAND already accepted has consumed it.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET)              seed <= SEED_INIT;
        else if (accept && is_rand) seed <= bus.iMUL_DATA;
    end

    execute_mul_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (iCLOCK),
        .reset_n (inRESET),
        .flush   (bus.iFREE_REFRESH),
        .write   (fifo_write),
        .wdata   (stg_data[LATENCY-1]),
        .pop     (pop),
        .rdata   (head),
        .count   (fifo_count)
    );

    assign bus.oNEXT_VALID           = fifo_valid;
    assign bus.oNEXT_DATA            = head.data;
    assign bus.oNEXT_FLAGS           = head.flags;
    assign bus.oNEXT_FLAGS_WRITEBACK = head.wb;
    assign bus.oNEXT_DESTINATION     = head.dest;

endmodule

`default_nettype wire

// File: tb/tb_execute_mul_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_mul_stage
// Brief    : Randomized and directed scoreboard bench for execute_mul_stage.
// Revision : 1.0
// ============================================================================

`ifndef EXE_MUL_MUL
`define EXE_MUL_MUL   5'h00
`endif
`ifndef EXE_MUL_MULH
`define EXE_MUL_MULH  5'h01
`endif
`ifndef EXE_MUL_UMULH
`define EXE_MUL_UMULH 5'h02
`endif
`ifndef EXE_MUL_RAND
`define EXE_MUL_RAND  5'h03
`endif

module tb_execute_mul_stage;
    import execute_mul_pkg::*;

    localparam int          LATENCY    = 2;
    localparam int          FIFO_DEPTH = 3;
    localparam logic [31:0] SEED_INIT  = SEED_INIT_DEFAULT;
    localparam logic [4:0]  C_MUL      = `EXE_MUL_MUL;
    localparam logic [4:0]  C_MULH     = `EXE_MUL_MULH;
    localparam logic [4:0]  C_UMULH    = `EXE_MUL_UMULH;
    localparam logic [4:0]  C_RAND     = `EXE_MUL_RAND;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_mul_stage_if bus ();

    execute_mul_stage #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SEED_INIT  (SEED_INIT)
    ) dut (
        .iCLOCK  (clk),
        .inRESET (rst_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the combinational unit: {result, SF,OF,CF,PF,ZF}.
    function automatic logic [36:0] unit_model(input logic [4:0] cmd, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] r;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        r  = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (cmd)
            C_MUL:   r = a * b;
            C_MULH:  begin p = 64'(sa * sb); r = p[63:32]; end
            C_UMULH: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            C_RAND:  return {{b[30:0], 1'b0} | {31'b0, b[0] & ~b[1]}, 5'b0};
            default: r = '0;
        endcase
        return {r, r[31], 1'b0, 1'b0, ~^r[7:0], (r == 32'b0)};
    endfunction

    assign {bus.iMUL_DATA, bus.iMUL_FLAGS} = unit_model(bus.oMUL_CMD, bus.oMUL_DATA_0, bus.oMUL_DATA_1);

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [31:0] data;
        logic [4:0]  flags;
        logic [4:0]  dest;
        logic        wb;
        int          ready;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_seed = SEED_INIT;
    int          cyc    = 0;
    logic        m_busy;
    logic        m_valid;
    logic [36:0] u;
    exp_t        e;

    initial begin
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst_n) begin
                q.delete();
                m_seed = SEED_INIT;
            end else begin
                m_busy  = (q.size() >= FIFO_DEPTH);
                m_valid = (q.size() > 0) && (q[0].ready <= cyc);
                check("prev_busy", 32'(bus.oPREV_BUSY), 32'(m_busy));
                check("next_valid", 32'(bus.oNEXT_VALID), 32'(m_valid));
                check("mul_cmd", 32'(bus.oMUL_CMD), 32'(bus.iCMD));
                check("mul_data_0", bus.oMUL_DATA_0, bus.iDATA_0);
                check("mul_data_1", bus.oMUL_DATA_1, (bus.iCMD == C_RAND) ? m_seed : bus.iDATA_1);
                if (m_valid && bus.oNEXT_VALID) begin
                    check("head_data", bus.oNEXT_DATA, q[0].data);
                    check("head_flags", 32'(bus.oNEXT_FLAGS), 32'(q[0].flags));
                    check("head_wb", 32'(bus.oNEXT_FLAGS_WRITEBACK), 32'(q[0].wb));
                    check("head_dest", 32'(bus.oNEXT_DESTINATION), 32'(q[0].dest));
                end
                if (bus.iFREE_REFRESH) begin
                    q.delete();
                end else begin
                    if (m_valid && !bus.iNEXT_BUSY) void'(q.pop_front());
                    if (bus.iPREV_VALID && !m_busy) begin
                        if (bus.iCMD == C_RAND) begin
                            u      = unit_model(C_RAND, 32'b0, m_seed);
                            m_seed = u[36:5];
                        end else begin
                            u = unit_model(bus.iCMD, bus.iDATA_0, bus.iDATA_1);
                        end
                        e.data  = u[36:5];
                        e.flags = u[4:0];
                        e.dest  = bus.iDESTINATION;
                        e.wb    = (bus.iCMD != C_RAND);
                        e.ready = cyc + LATENCY + 1;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [4:0] cmds [4] = '{C_MUL, C_MULH, C_UMULH, C_RAND};

    task automatic idle();
        bus.iPREV_VALID   = 1'b0;
        bus.iFREE_REFRESH = 1'b0;
        bus.iCMD          = C_MUL;
        bus.iDATA_0       = '0;
        bus.iDATA_1       = '0;
        bus.iDESTINATION  = '0;
    endtask

    task automatic drive(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        bus.iPREV_VALID  = 1'b1;
        bus.iCMD         = cmd;
        bus.iDATA_0      = a;
        bus.iDATA_1      = b;
        bus.iDESTINATION = d;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_head(input string name, input logic [31:0] d, input logic [4:0] f,
                              input logic wb, input logic [4:0] dest);
        check({name, "_valid"}, 32'(bus.oNEXT_VALID), 32'd1);
        check({name, "_data"}, bus.oNEXT_DATA, d);
        check({name, "_flags"}, 32'(bus.oNEXT_FLAGS), 32'(f));
        check({name, "_wb"}, 32'(bus.oNEXT_FLAGS_WRITEBACK), 32'(wb));
        check({name, "_dest"}, 32'(bus.oNEXT_DESTINATION), 32'(dest));
    endtask

    int n_acc;
    int w;

    initial begin
        idle();
        bus.iNEXT_BUSY = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(bus.oNEXT_VALID), 32'd0);
        check("rst_busy", 32'(bus.oPREV_BUSY), 32'd0);
        check("rst_data", bus.oNEXT_DATA, 32'd0);
        check("rst_flags", 32'(bus.oNEXT_FLAGS), 32'd0);
        check("rst_wb", 32'(bus.oNEXT_FLAGS_WRITEBACK), 32'd0);
        check("rst_dest", 32'(bus.oNEXT_DESTINATION), 32'd0);

        // three RANDs straight after reset
        @(negedge clk); drive(C_RAND, $urandom, $urandom, 5'd1);
        @(negedge clk); bus.iDESTINATION = 5'd2;
        @(negedge clk); bus.iDESTINATION = 5'd3;
        @(negedge clk); idle(); #1; check_head("rand0", 32'h0000_0003, 5'h00, 1'b0, 5'd1);
        @(negedge clk); #1;         check_head("rand1", 32'h0000_0006, 5'h00, 1'b0, 5'd2);
        @(negedge clk); #1;         check_head("rand2", 32'h0000_000C, 5'h00, 1'b0, 5'd3);

        // MUL 3*5 latency
        @(negedge clk); drive(C_MUL, 32'd3, 32'd5, 5'd7);
        @(negedge clk); idle();
        @(negedge clk); #1; check("mul_early_valid", 32'(bus.oNEXT_VALID), 32'd0);
        @(negedge clk); #1; check_head("mul", 32'h0000_000F, 5'h02, 1'b1, 5'd7);

        // UMULH of all-ones
        @(negedge clk); drive(C_UMULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk); #1; check_head("umulh", 32'hFFFF_FFFE, 5'h10, 1'b1, 5'd3);

        // writeback stalled, dispatch continuous
        @(negedge clk);
        bus.iNEXT_BUSY = 1'b1;
        drive(C_MUL, $urandom, $urandom, 5'd9);
        n_acc = 0;
        repeat (8) begin
            #4;
            if (!bus.oPREV_BUSY) n_acc++;
            @(negedge clk);
            bus.iDATA_0      = $urandom;
            bus.iDESTINATION = bus.iDESTINATION + 5'd1;
        end
        check("bp_accepts", 32'(n_acc), 32'(FIFO_DEPTH));
        check("bp_busy", 32'(bus.oPREV_BUSY), 32'd1);
        idle();
        bus.iNEXT_BUSY = 1'b0;
        @(negedge clk); #1; check("bp_busy_release", 32'(bus.oPREV_BUSY), 32'd0);
        repeat (5) @(negedge clk);

        // flush with two in flight and dispatch valid
        drive(C_MUL, $urandom, $urandom, 5'd11);
        @(negedge clk); bus.iDATA_0 = $urandom; bus.iDESTINATION = 5'd12;
        @(negedge clk); bus.iFREE_REFRESH = 1'b1;
        @(negedge clk); idle(); #1;
        check("flush_valid0", 32'(bus.oNEXT_VALID), 32'd0);
        check("flush_busy", 32'(bus.oPREV_BUSY), 32'd0);
        @(negedge clk); #1; check("flush_valid1", 32'(bus.oNEXT_VALID), 32'd0);
        drive(C_MUL, 32'd6, 32'd7, 5'd13);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk); #1; check_head("post_flush", 32'h0000_002A, 5'h00, 1'b1, 5'd13);

        // reset while the FIFO holds two entries
        @(negedge clk);
        bus.iNEXT_BUSY = 1'b1;
        drive(C_MULH, $urandom, $urandom, 5'd20);
        @(negedge clk); bus.iDESTINATION = 5'd21;
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
        #1; check("pre_rst_valid", 32'(bus.oNEXT_VALID), 32'd1);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        check("midrst_valid", 32'(bus.oNEXT_VALID), 32'd0);
        check("midrst_busy", 32'(bus.oPREV_BUSY), 32'd0);
        bus.iNEXT_BUSY = 1'b0;
        drive(C_RAND, $urandom, $urandom, 5'd22);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk); #1; check_head("rst_rand", 32'h0000_0003, 5'h00, 1'b0, 5'd22);

        // randomized traffic
        repeat (600) begin
            @(negedge clk);
            bus.iPREV_VALID   = ($urandom_range(0, 9) < 7);
            bus.iCMD          = cmds[$urandom_range(0, 3)];
            bus.iDATA_0       = pick();
            bus.iDATA_1       = pick();
            bus.iDESTINATION  = 5'($urandom);
            bus.iNEXT_BUSY    = ($urandom_range(0, 9) < 3);
            bus.iFREE_REFRESH = ($urandom_range(0, 49) == 0);
        end

        @(negedge clk);
        idle();
        bus.iNEXT_BUSY = 1'b0;
        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("drain_left", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

`default_nettype wire
